// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main entry plus skid entry, registered upstream ready,
// synchronous flush with bubble insertion and a saturating count of dropped entries.
module pipe_stage_elastic #(
    parameter int                CTRL_W      = 12,
    parameter int                DATA_W      = 64,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                DROP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              main_v, main_v_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic              skid_v, skid_v_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [DROP_W-1:0] drop_cnt_nxt;
    logic [DROP_W:0]   drop_sum;
    logic              acc;
    logic              pop;

    assign in_ready  = ~skid_v & ~flush;
    assign acc       = in_valid & in_ready;
    assign pop       = main_v & out_ready & ~stall;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : BUBBLE_CTRL;
    assign out_data  = main_v ? main_data : '0;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // One extra bit catches overflow so the counter can stick at all-ones.
    assign drop_sum = {1'b0, drop_cnt} + {{(DROP_W-1){1'b0}}, occupancy};

    always_comb begin
        main_v_nxt    = main_v;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
        skid_v_nxt    = skid_v;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        drop_cnt_nxt  = drop_cnt;

        if (flush) begin
            main_v_nxt    = 1'b0;
            main_ctrl_nxt = BUBBLE_CTRL;
            main_data_nxt = '0;
            skid_v_nxt    = 1'b0;
            skid_ctrl_nxt = BUBBLE_CTRL;
            skid_data_nxt = '0;
            drop_cnt_nxt  = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end else if (!main_v || (pop && !skid_v)) begin
            main_v_nxt    = acc;
            main_ctrl_nxt = acc ? in_ctrl : BUBBLE_CTRL;
            main_data_nxt = acc ? in_data : '0;
        end else if (pop) begin
            // Skid is valid here, so in_ready was low and no beat arrives this cycle.
            main_v_nxt    = 1'b1;
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
            skid_v_nxt    = 1'b0;
            skid_ctrl_nxt = BUBBLE_CTRL;
            skid_data_nxt = '0;
        end else if (acc) begin
            skid_v_nxt    = 1'b1;
            skid_ctrl_nxt = in_ctrl;
            skid_data_nxt = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_v    <= 1'b0;
            skid_ctrl <= BUBBLE_CTRL;
            skid_data <= '0;
            drop_cnt  <= '0;
        end else begin
            main_v    <= main_v_nxt;
            main_ctrl <= main_ctrl_nxt;
            main_data <= main_data_nxt;
            skid_v    <= skid_v_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline stage register, the successor to the fixed-format ID/EX-style stage registers.
- Carries a control field and a data field, with a valid/ready handshake on both sides.
- Uses a two-entry main+skid buffer, so the upstream ready is registered and full throughput holds under backpressure.
- Supports stall, flush with bubble insertion, and a count of discarded instructions. It is used between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 12, width of the control field (reg_write, mem_read, alu_op, ...).
- DATA_W, 64, width of the data field (pc, operands, register indices, immediate).
- BUBBLE_CTRL, 0, control value driven for an empty or flushed slot.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; kills all held entries and any incoming beat.
- stall  in  1  downstream freeze; treated as out_ready=0.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main entry control; BUBBLE_CTRL when not out_valid.
- out_data  out  DATA_W  main entry data; 0 when not out_valid.
- occupancy  out  2  number of valid entries, 0..2.
- drop_cnt  out  DROP_W  saturating count of valid entries discarded by flush.

Behaviour:
- Storage: main entry (main_v, ctrl, data) and skid entry (skid_v, ctrl, data).
- Accept: acc = in_valid & in_ready.
- Pop: pop = out_valid & out_ready & ~stall.
- in_ready = ~skid_v & ~flush. skid_v is registered; flush is the only combinational term.
- out_valid = main_v. out_ctrl and out_data are driven from the main entry, or BUBBLE_CTRL and 0 when main_v=0.
- Latency: one cycle from acceptance into an empty stage to out_valid.
- Throughput: one beat per cycle when out_ready=1 and stall=0.
- Next state (flush=0):
  - Main empty, or main popping with skid empty: an accepted beat loads main.
  - Main popping with skid valid: skid moves to main. An accepted beat in the same cycle cannot occur because in_ready=0.
  - Main held (not popping) and acc: the beat loads skid, and in_ready drops the next cycle.
  - Order is always preserved: the main entry leaves before the skid entry.
- Flush (highest priority, at the clock edge):
  - main_v and skid_v clear.
  - Stored ctrl is set to BUBBLE_CTRL and stored data to 0.
  - The incoming beat is discarded; in_ready reads 0 that cycle.
  - drop_cnt += main_v + skid_v, saturating at all-ones. A pop in the same cycle is honoured for downstream but the popped entry is still counted.
  - Flush and stall together: flush wins.
- Stall: freezes the main entry. The stage can still absorb one beat into skid.
- occupancy = main_v + skid_v, combinational from registers.
- Reset (async, any time, including mid-transfer): main_v=0, skid_v=0, stored ctrl=BUBBLE_CTRL, stored data=0, drop_cnt=0.
  - Outputs while in reset: out_valid=0, in_ready=1, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0.
  - First acceptance is possible on the first edge after rst_n rises.
- Invariant: skid_v=1 implies main_v=1; the state main empty with skid valid never occurs.

Test Plan:
- Reset: drive rst_n=0 mid-stream with occupancy=2, async between edges -> immediately out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, drop_cnt=0.
- Streaming: out_ready=1; send ctrl 12'h0A5 / data 64'h1234_ABCD then ctrl 12'h0A6 / data 64'h1235_ABCD on consecutive cycles -> each appears one cycle later in order, with out_valid held high for two cycles.
- Backpressure: out_ready=0; send beats A, B, C -> A in main, B in skid, in_ready=0 after B, C held upstream. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Stall: stall=1 with out_ready=1 for 3 cycles while holding A -> out_data stays A and no pop occurs. Release -> A pops once.
- Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_ctrl=BUBBLE_CTRL, incoming beat dropped, drop_cnt=2. Repeat 128 times with DROP_W=8 -> drop_cnt=255, saturated.
- Simultaneous: at full occupancy, pop and flush in the same cycle -> downstream sees the main beat, then occupancy=0 and drop_cnt increments by 2.
